// File: rtl/inst_mem_loader.sv
// Writable instruction memory fed by a byte-serial, length-prefixed loader.
// The host streams LEN_HI, LEN_LO, then 4*N big-endian bytes. Fetch reads the
// RAM combinationally by PC. Reads return NOP until a complete program is loaded.
module inst_mem_loader #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        cpu_hold,
    output logic        loaded,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t            state, state_nxt;
    logic [15:0]       len;
    logic [15:0]       word_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_q;
    logic [ADDR_W:0]   valid_words;
    logic              loaded_q, done_q, overflow_q;
    logic [31:0]       mem [DEPTH];

    logic              xfer, start, word_last, last_word, in_range, enter_done, mem_we;
    logic [31:0]       word_asm;
    logic [15:0]       len_eff;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_ok;
    logic              unused_pc_lo;

    assign xfer      = in_valid && in_ready;
    assign start     = load_start && (state == S_IDLE || state == S_DONE);
    assign word_last = (byte_idx == 2'd3);
    assign last_word = ((word_cnt + 16'd1) == len);
    assign in_range  = ({1'b0, word_cnt} < DEPTH_W);
    assign word_asm  = {asm_q, in_data};
    assign mem_we    = (state == S_DATA) && xfer && word_last && in_range;
    // In LEN_LO the low length byte is still on in_data when DONE is entered
    assign len_eff   = (state == S_LEN_LO) ? {len[15:8], in_data} : len;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and byte-interface handshake
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ({len[15:8], in_data} == 16'd0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && word_last && last_word) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (load_start) state_nxt = S_LEN_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

    // Length capture, word assembly, counters and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            len         <= '0;
            word_cnt    <= '0;
            byte_idx    <= '0;
            asm_q       <= '0;
            valid_words <= '0;
            loaded_q    <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= enter_done;
            if (start) begin
                loaded_q   <= 1'b0;
                overflow_q <= 1'b0;
                word_cnt   <= '0;
                byte_idx   <= '0;
            end
            if (xfer) begin
                case (state)
                    S_LEN_HI: len[15:8] <= in_data;
                    S_LEN_LO: len[7:0]  <= in_data;
                    S_DATA: begin
                        asm_q    <= {asm_q[15:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (word_last) begin
                            word_cnt <= word_cnt + 16'd1;
                            if (!in_range) overflow_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (enter_done) begin
                loaded_q    <= 1'b1;
                valid_words <= ({1'b0, len_eff} >= DEPTH_W) ? DEPTH_W[ADDR_W:0] : len_eff[ADDR_W:0];
            end
        end
    end

    // Instruction RAM write port; contents survive reset and are masked on read
    always_ff @(posedge clk) begin
        if (mem_we) mem[word_cnt[ADDR_W-1:0]] <= word_asm;
    end

    assign rd_idx       = PC[ADDR_W+1:2];
    assign rd_ok        = loaded_q && (PC[31:ADDR_W+2] == '0) && ({1'b0, rd_idx} < valid_words);
    assign Instruction  = rd_ok ? mem[rd_idx] : '0;
    assign unused_pc_lo = ^PC[1:0];

    assign loaded   = loaded_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign cpu_hold = !loaded_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed testbench for inst_mem_loader: a DEPTH=128 instance plus a DEPTH=4
// instance sharing all inputs, the latter used for overflow behaviour.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst, load_start, in_valid;
    logic [7:0]  in_data;
    logic [31:0] PC;
    logic        in_ready, cpu_hold, loaded, done, overflow;
    logic [31:0] instr;
    logic        in_ready4, cpu_hold4, loaded4, done4, overflow4;
    logic [31:0] instr4;

    int unsigned checks = 0;
    int unsigned passes = 0;
    logic [7:0]  q[$];
    logic        early_done;

    always #5 clk = ~clk;

    inst_mem_loader #(.DEPTH(128), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .PC(PC), .Instruction(instr),
        .cpu_hold(cpu_hold), .loaded(loaded), .done(done), .overflow(overflow)
    );

    inst_mem_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready4), .PC(PC), .Instruction(instr4),
        .cpu_hold(cpu_hold4), .loaded(loaded4), .done(done4), .overflow(overflow4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Sends q; returns at #1 after the edge accepting the last byte
    task automatic send_bytes(input bit gap);
        early_done = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                tick();
                early_done |= done;
            end
            in_valid = 1'b1;
            in_data  = q[i];
            tick();
            if (i < q.size() - 1) early_done |= done;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00; PC = 32'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (instr !== 32'h0) $display("FAIL reset_pc0 got %h exp %h", instr, 32'h0); else passes++;
        PC = 32'd8; #1;
        checks++; if (instr !== 32'h0) $display("FAIL reset_pc8 got %h exp %h", instr, 32'h0); else passes++;
        checks++; if (cpu_hold !== 1'b1) $display("FAIL reset_cpu_hold got %b exp 1", cpu_hold); else passes++;
        checks++; if (loaded !== 1'b0) $display("FAIL reset_loaded got %b exp 0", loaded); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else passes++;
        checks++; if (done !== 1'b0 || overflow !== 1'b0) $display("FAIL reset_done_ovf got %b%b exp 00", done, overflow); else passes++;
    endtask

    task automatic check_basic_image(input string tag);
        checks++; if (done !== 1'b1) $display("FAIL %s_done got %b exp 1", tag, done); else passes++;
        checks++; if (early_done !== 1'b0) $display("FAIL %s_early_done got %b exp 0", tag, early_done); else passes++;
        checks++; if (loaded !== 1'b1 || cpu_hold !== 1'b0) $display("FAIL %s_loaded_hold got %b%b exp 10", tag, loaded, cpu_hold); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL %s_in_ready got %b exp 0", tag, in_ready); else passes++;
        PC = 32'd0; #1;
        checks++; if (instr !== 32'h8001060A) $display("FAIL %s_pc0 got %h exp %h", tag, instr, 32'h8001060A); else passes++;
        PC = 32'd4; #1;
        checks++; if (instr !== 32'h0) $display("FAIL %s_pc4 got %h exp %h", tag, instr, 32'h0); else passes++;
        PC = 32'd8; #1;
        checks++; if (instr !== 32'h0) $display("FAIL %s_pc8 got %h exp %h", tag, instr, 32'h0); else passes++;
        PC = 32'd3; #1;
        checks++; if (instr !== 32'h8001060A) $display("FAIL %s_pc3 got %h exp %h", tag, instr, 32'h8001060A); else passes++;
        tick();
        checks++; if (done !== 1'b0) $display("FAIL %s_done_len got %b exp 0", tag, done); else passes++;
    endtask

    task automatic test_basic_load();
        pulse_start();
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_ready_len got %b exp 1", in_ready); else passes++;
        q = '{8'h00, 8'h02, 8'h80, 8'h01, 8'h06, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(1'b0);
        check_basic_image("basic");
    endtask

    task automatic test_gapped_load();
        pulse_start();
        q = '{8'h00, 8'h02, 8'h80, 8'h01, 8'h06, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(1'b1);
        check_basic_image("gapped");
    endtask

    task automatic test_zero_len();
        pulse_start();
        q = '{8'h00, 8'h00};
        send_bytes(1'b0);
        checks++; if (done !== 1'b1 || loaded !== 1'b1) $display("FAIL zero_done_loaded got %b%b exp 11", done, loaded); else passes++;
        PC = 32'd0; #1;
        checks++; if (instr !== 32'h0) $display("FAIL zero_pc0 got %h exp %h", instr, 32'h0); else passes++;
        PC = 32'd4; #1;
        checks++; if (instr !== 32'h0) $display("FAIL zero_pc4 got %h exp %h", instr, 32'h0); else passes++;
        tick();
    endtask

    task automatic test_overflow();
        pulse_start();
        q = '{8'h00, 8'h05, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
              8'h33, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h44, 8'h55, 8'h55, 8'h55, 8'h55};
        send_bytes(1'b0);
        checks++; if (done4 !== 1'b1 || loaded4 !== 1'b1) $display("FAIL ovf_done_loaded got %b%b exp 11", done4, loaded4); else passes++;
        checks++; if (overflow4 !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow4); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_flag_deep got %b exp 0", overflow); else passes++;
        PC = 32'd0;  #1;
        checks++; if (instr4 !== 32'h11111111) $display("FAIL ovf_w0 got %h exp %h", instr4, 32'h11111111); else passes++;
        PC = 32'd4;  #1;
        checks++; if (instr4 !== 32'h22222222) $display("FAIL ovf_w1 got %h exp %h", instr4, 32'h22222222); else passes++;
        PC = 32'd8;  #1;
        checks++; if (instr4 !== 32'h33333333) $display("FAIL ovf_w2 got %h exp %h", instr4, 32'h33333333); else passes++;
        PC = 32'd12; #1;
        checks++; if (instr4 !== 32'h44444444) $display("FAIL ovf_w3 got %h exp %h", instr4, 32'h44444444); else passes++;
        PC = 32'd16; #1;
        checks++; if (instr4 !== 32'h0) $display("FAIL ovf_pc16 got %h exp %h", instr4, 32'h0); else passes++;
        checks++; if (instr !== 32'h55555555) $display("FAIL ovf_deep_w4 got %h exp %h", instr, 32'h55555555); else passes++;
        PC = 32'h0000_0200; #1;
        checks++; if (instr !== 32'h0) $display("FAIL ovf_pc_high got %h exp %h", instr, 32'h0); else passes++;
        tick();
        checks++; if (overflow4 !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow4); else passes++;
    endtask

    task automatic test_abort_reload();
        pulse_start();
        checks++; if (overflow4 !== 1'b0 || loaded4 !== 1'b0) $display("FAIL abort_start_clear got %b%b exp 00", overflow4, loaded4); else passes++;
        q = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_bytes(1'b0);
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL abort_in_ready got %b exp 0", in_ready); else passes++;
        checks++; if (loaded !== 1'b0 || cpu_hold !== 1'b1) $display("FAIL abort_loaded_hold got %b%b exp 01", loaded, cpu_hold); else passes++;
        PC = 32'd0; #1;
        checks++; if (instr !== 32'h0) $display("FAIL abort_masked got %h exp %h", instr, 32'h0); else passes++;
        rst = 1'b0;
        tick();
        pulse_start();
        // load_start pulses mid-stream must not restart the load
        early_done = 1'b0;
        q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        for (int i = 0; i < q.size(); i++) begin
            in_valid   = 1'b1;
            in_data    = q[i];
            load_start = (i == 3 || i == 7);
            tick();
            if (i < q.size() - 1) early_done |= done;
        end
        in_valid = 1'b0; load_start = 1'b0;
        checks++; if (done !== 1'b1 || early_done !== 1'b0) $display("FAIL reload_done got %b/%b exp 1/0", done, early_done); else passes++;
        PC = 32'd0; #1;
        checks++; if (instr !== 32'hDEADBEEF) $display("FAIL reload_w0 got %h exp %h", instr, 32'hDEADBEEF); else passes++;
        PC = 32'd4; #1;
        checks++; if (instr !== 32'h01234567) $display("FAIL reload_w1 got %h exp %h", instr, 32'h01234567); else passes++;
        PC = 32'd8; #1;
        checks++; if (instr !== 32'h0) $display("FAIL reload_w2 got %h exp %h", instr, 32'h0); else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_zero_len();
        test_overflow();
        test_abort_reload();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
